pbus_interconnect: RTL and testbench

Parametrised picorv32 native-bus interconnect that replaces the hand-written address decode in the SoC top. It decodes the upper address bits into one of `NSLAVES` regions, forwards select, ready and read data, and adds bus-error handling. Unmapped or disabled regions and unresponsive slaves are completed by the interconnect itself with an error read value, a latched error address and an interrupt. It sits directly between the CPU memory port and the peripherals (RAM, UART, LED, LCD, …).

---
 rtl/pbus_interconnect.sv | 143 ++++++++++++++
 tb/tb_pbus_interconnect.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_interconnect.sv
// picorv32 native-bus interconnect: region decode, slave mux, and bus-error
// completion for unmapped regions and stalled slaves.
module pbus_interconnect #(
  parameter int unsigned          REGION_BITS = 4,
  parameter int unsigned          NSLAVES     = 8,
  parameter logic [NSLAVES-1:0]   SLAVE_EN    = '1,
  parameter int unsigned          TIMEOUT     = 1023,
  parameter logic [31:0]          ERR_RDATA   = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  input  logic [31:0]             mem_addr,
  input  logic [3:0]              mem_wstrb,
  output logic                    mem_ready,
  output logic [31:0]             mem_rdata,
  output logic [NSLAVES-1:0]      slv_sel,
  input  logic [NSLAVES-1:0]      slv_ready,
  input  logic [32*NSLAVES-1:0]   slv_rdata,
  input  logic                    err_clr,
  output logic                    err_irq,
  output logic [31:0]             err_addr,
  output logic                    err_write,
  output logic [7:0]              err_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ECNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_irq_q, err_irq_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic                err_write_q, err_write_d;
  logic [ECNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [REGION_BITS-1:0] idx;
  logic [NSLAVES-1:0]     hit;
  logic [DATA_W-1:0]      rdata_hit;
  logic                   mapped;
  logic                   slv_rdy_hit;
  logic                   in_wait;
  logic                   req;
  logic                   timeout_err;
  logic                   unmap_err;
  logic                   err_done;

  assign idx = mem_addr[31 -: REGION_BITS];

  // Region decode: at most one hit bit, only for enabled slaves in range.
  always_comb begin
    hit       = '0;
    rdata_hit = '0;
    for (int unsigned i = 0; i < NSLAVES; i++) begin
      if (idx == REGION_BITS'(i) && SLAVE_EN[i]) begin
        hit[i]    = 1'b1;
        rdata_hit = slv_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Completion and select; the mapped path stays purely combinational.
  always_comb begin
    mapped      = |hit;
    slv_rdy_hit = |(hit & slv_ready);
    in_wait     = (state_q == S_WAIT);
    req         = mem_valid & ~rst;
    timeout_err = req & mapped & ~slv_rdy_hit & in_wait &
                  (cnt_q == CNT_W'(TIMEOUT));
    unmap_err   = req & ~mapped & in_wait & (cnt_q == CNT_W'(1));
    err_done    = timeout_err | unmap_err;
    slv_sel     = (req & ~timeout_err) ? hit : '0;
    mem_ready   = (req & mapped & slv_rdy_hit) | err_done;
    mem_rdata   = (|slv_sel) ? rdata_hit : ERR_RDATA;
  end

  // Next-state: wait counter, access FSM and error capture.
  always_comb begin
    cnt_d       = cnt_q;
    state_d     = state_q;
    err_irq_d   = err_irq_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    err_cnt_d   = err_cnt_q;

    if (!mem_valid || mem_ready) cnt_d = '0;
    else                         cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: if (mem_valid) state_d = mem_ready ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (!mem_valid)     state_d = S_IDLE;
        else if (mem_ready) state_d = S_DONE;
      end
      S_DONE: begin
        if (!mem_valid)     state_d = S_IDLE;
        else                state_d = mem_ready ? S_DONE : S_WAIT;
      end
      default:              state_d = S_IDLE;
    endcase

    // A new error outranks a coincident clear so no event is lost.
    if (err_done) begin
      err_irq_d   = 1'b1;
      err_addr_d  = mem_addr;
      err_write_d = |mem_wstrb;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ECNT_W'(1);
    end else if (err_clr) begin
      err_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_irq_q   <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_irq_q   <= err_irq_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_irq   = err_irq_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pbus_interconnect.sv
// Directed bench for pbus_interconnect: decode, unmapped and timeout errors,
// irq clear race, error count saturation and reset mid-access.
module tb_pbus_interconnect;

  localparam int unsigned NS = 8;

  logic          clk;
  logic          rst;
  logic          mem_valid;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [NS-1:0] slv_sel;
  logic [NS-1:0] slv_ready;
  logic [32*NS-1:0] slv_rdata;
  logic          err_clr;
  logic          err_irq;
  logic [31:0]   err_addr;
  logic          err_write;
  logic [7:0]    err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pbus_interconnect #(
    .REGION_BITS(4),
    .NSLAVES    (NS),
    .SLAVE_EN   (8'h7F),
    .TIMEOUT    (16),
    .ERR_RDATA  (32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .slv_sel  (slv_sel),
    .slv_ready(slv_ready),
    .slv_rdata(slv_rdata),
    .err_clr  (err_clr),
    .err_irq  (err_irq),
    .err_addr (err_addr),
    .err_write(err_write),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wstrb = '0;
    slv_ready = '0; slv_rdata = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (mem_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", mem_ready); else n_pass++;
    n_checks++; if (slv_sel !== 8'h00) $display("FAIL rst_sel: got %h expected 00", slv_sel); else n_pass++;
    n_checks++; if (err_irq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", err_irq); else n_pass++;
    n_checks++; if (err_addr !== 32'h0) $display("FAIL rst_eaddr: got %h expected 0", err_addr); else n_pass++;
    n_checks++; if (err_write !== 1'b0) $display("FAIL rst_ewrite: got %b expected 0", err_write); else n_pass++;
    n_checks++; if (err_cnt !== 8'h00) $display("FAIL rst_ecnt: got %h expected 00", err_cnt); else n_pass++;
    n_checks++; if (mem_rdata !== 32'hDEADBEEF) $display("FAIL rst_rdata: got %h expected deadbeef", mem_rdata); else n_pass++;
    // Request held during reset must not reach any slave.
    @(negedge clk); mem_valid = 1'b1; slv_ready = 8'hFF; #1;
    n_checks++; if (slv_sel !== 8'h00 || mem_ready !== 1'b0)
      $display("FAIL rst_gate: got sel=%h ready=%b expected sel=00 ready=0", slv_sel, mem_ready); else n_pass++;
    @(negedge clk); rst = 1'b0; mem_valid = 1'b0; slv_ready = '0;
  endtask

  task automatic test_mapped_read();
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wstrb = 4'h0; #1;
    n_checks++; if (slv_sel !== 8'h01 || mem_ready !== 1'b0)
      $display("FAIL rd0_c0: got sel=%h ready=%b expected sel=01 ready=0", slv_sel, mem_ready); else n_pass++;
    @(negedge clk); slv_ready = 8'h01; slv_rdata[31:0] = 32'h12345678; #1;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL rd0_ready: got %b expected 1", mem_ready); else n_pass++;
    n_checks++; if (mem_rdata !== 32'h12345678) $display("FAIL rd0_rdata: got %h expected 12345678", mem_rdata); else n_pass++;
    @(negedge clk); mem_valid = 1'b0; slv_ready = '0; #1;
    n_checks++; if (mem_ready !== 1'b0 || err_cnt !== 8'h00)
      $display("FAIL rd0_after: got ready=%b ecnt=%h expected ready=0 ecnt=00", mem_ready, err_cnt); else n_pass++;
    // Region 5: an unselected slave's ready must be ignored.
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h5000_0100; slv_ready = 8'h01;
    slv_rdata[5*32 +: 32] = 32'hCAFEF00D; #1;
    n_checks++; if (slv_sel !== 8'h20 || mem_ready !== 1'b0)
      $display("FAIL rd5_c0: got sel=%h ready=%b expected sel=20 ready=0", slv_sel, mem_ready); else n_pass++;
    @(negedge clk); slv_ready = 8'h20; #1;
    n_checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFEF00D)
      $display("FAIL rd5_c1: got ready=%b rdata=%h expected ready=1 rdata=cafef00d", mem_ready, mem_rdata); else n_pass++;
    @(negedge clk); mem_valid = 1'b0; slv_ready = '0;
  endtask

  task automatic test_unmapped();
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h7000_0004; mem_wstrb = 4'hF; slv_ready = 8'hFF; #1;
    n_checks++; if (slv_sel !== 8'h00 || mem_ready !== 1'b0)
      $display("FAIL um7_c0: got sel=%h ready=%b expected sel=00 ready=0", slv_sel, mem_ready); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (slv_sel !== 8'h00 || mem_ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF)
      $display("FAIL um7_c1: got sel=%h ready=%b rdata=%h expected sel=00 ready=1 rdata=deadbeef",
               slv_sel, mem_ready, mem_rdata); else n_pass++;
    @(negedge clk); mem_valid = 1'b0; mem_wstrb = 4'h0; slv_ready = '0; #1;
    n_checks++; if (err_addr !== 32'h7000_0004) $display("FAIL um7_eaddr: got %h expected 70000004", err_addr); else n_pass++;
    n_checks++; if (err_write !== 1'b1) $display("FAIL um7_ewrite: got %b expected 1", err_write); else n_pass++;
    n_checks++; if (err_irq !== 1'b1) $display("FAIL um7_irq: got %b expected 1", err_irq); else n_pass++;
    n_checks++; if (err_cnt !== 8'd1) $display("FAIL um7_ecnt: got %0d expected 1", err_cnt); else n_pass++;
    // Region 8 is beyond NSLAVES.
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h8000_0000; #1;
    @(negedge clk); #1;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL um8_ready: got %b expected 1", mem_ready); else n_pass++;
    @(negedge clk); mem_valid = 1'b0; #1;
    n_checks++; if (err_write !== 1'b0 || err_cnt !== 8'd2 || err_addr !== 32'h8000_0000)
      $display("FAIL um8_regs: got w=%b cnt=%0d addr=%h expected w=0 cnt=2 addr=80000000",
               err_write, err_cnt, err_addr); else n_pass++;
  endtask

  task automatic test_timeout();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; #1;
    n_checks++; if (err_irq !== 1'b0) $display("FAIL to_clr: got %b expected 0", err_irq); else n_pass++;
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h2000_0000; mem_wstrb = 4'h0; slv_ready = '0;
    for (int k = 0; k < 16; k++) begin
      #1;
      n_checks++; if (slv_sel !== 8'h04 || mem_ready !== 1'b0)
        $display("FAIL to_wait: cycle %0d got sel=%h ready=%b expected sel=04 ready=0", k, slv_sel, mem_ready); else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF || slv_sel !== 8'h00)
      $display("FAIL to_c16: got ready=%b rdata=%h sel=%h expected ready=1 rdata=deadbeef sel=00",
               mem_ready, mem_rdata, slv_sel); else n_pass++;
    @(negedge clk); mem_valid = 1'b0; #1;
    n_checks++; if (err_irq !== 1'b1 || err_cnt !== 8'd3 || err_addr !== 32'h2000_0000 || err_write !== 1'b0)
      $display("FAIL to_regs: got irq=%b cnt=%0d addr=%h w=%b expected irq=1 cnt=3 addr=20000000 w=0",
               err_irq, err_cnt, err_addr, err_write); else n_pass++;
  endtask

  task automatic test_timeout_race();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h2000_0040; slv_ready = '0;
    repeat (16) @(negedge clk);
    slv_ready = 8'h04; slv_rdata[2*32 +: 32] = 32'hA5A5A5A5; #1;
    n_checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'hA5A5A5A5 || slv_sel !== 8'h04)
      $display("FAIL race_c16: got ready=%b rdata=%h sel=%h expected ready=1 rdata=a5a5a5a5 sel=04",
               mem_ready, mem_rdata, slv_sel); else n_pass++;
    @(negedge clk); mem_valid = 1'b0; slv_ready = '0; #1;
    n_checks++; if (err_irq !== 1'b0 || err_cnt !== 8'd3 || err_addr !== 32'h2000_0000)
      $display("FAIL race_regs: got irq=%b cnt=%0d addr=%h expected irq=0 cnt=3 addr=20000000",
               err_irq, err_cnt, err_addr); else n_pass++;
  endtask

  task automatic test_err_clr_race();
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h7000_0008; mem_wstrb = 4'h0;
    @(negedge clk); err_clr = 1'b1; #1;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL clr_ready: got %b expected 1", mem_ready); else n_pass++;
    @(negedge clk); err_clr = 1'b0; mem_valid = 1'b0; #1;
    n_checks++; if (err_irq !== 1'b1 || err_cnt !== 8'd4 || err_addr !== 32'h7000_0008)
      $display("FAIL clr_race: got irq=%b cnt=%0d addr=%h expected irq=1 cnt=4 addr=70000008",
               err_irq, err_cnt, err_addr); else n_pass++;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; #1;
    n_checks++; if (err_irq !== 1'b0) $display("FAIL clr_alone: got %b expected 0", err_irq); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int seen = 0;
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h9000_0000; mem_wstrb = 4'h1;
    for (int k = 0; k < 600; k++) begin
      #1;
      if (mem_ready !== ((k % 2) == 1)) bad++;
      if (mem_ready === 1'b1) seen++;
      @(negedge clk);
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0; #1;
    n_checks++; if (bad != 0 || seen != 300)
      $display("FAIL b2b_pattern: got %0d bad cycles and %0d completions, expected 0 and 300", bad, seen); else n_pass++;
    n_checks++; if (err_cnt !== 8'd255) $display("FAIL b2b_sat: got %0d expected 255", err_cnt); else n_pass++;
    n_checks++; if (err_write !== 1'b1 || err_addr !== 32'h9000_0000)
      $display("FAIL b2b_regs: got w=%b addr=%h expected w=1 addr=90000000", err_write, err_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); mem_valid = 1'b1; mem_addr = 32'h2000_0000; slv_ready = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1; #1;
    n_checks++; if (slv_sel !== 8'h00 || mem_ready !== 1'b0 || mem_rdata !== 32'hDEADBEEF)
      $display("FAIL rmid_gate: got sel=%h ready=%b rdata=%h expected sel=00 ready=0 rdata=deadbeef",
               slv_sel, mem_ready, mem_rdata); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (err_cnt !== 8'd0 || err_irq !== 1'b0 || err_addr !== 32'h0 || err_write !== 1'b0)
      $display("FAIL rmid_regs: got cnt=%0d irq=%b addr=%h w=%b expected all 0",
               err_cnt, err_irq, err_addr, err_write); else n_pass++;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      n_checks++; if (slv_sel !== 8'h04 || mem_ready !== 1'b0)
        $display("FAIL rmid_wait: cycle %0d got sel=%h ready=%b expected sel=04 ready=0", k, slv_sel, mem_ready); else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++; if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF)
      $display("FAIL rmid_to: got ready=%b rdata=%h expected ready=1 rdata=deadbeef", mem_ready, mem_rdata); else n_pass++;
    @(negedge clk); mem_valid = 1'b0; #1;
    n_checks++; if (err_cnt !== 8'd1 || err_irq !== 1'b1)
      $display("FAIL rmid_after: got cnt=%0d irq=%b expected cnt=1 irq=1", err_cnt, err_irq); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_timeout();
    test_timeout_race();
    test_err_clr_race();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
